// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: data width and ALUCtrl operation codes.
package alu_pkg;

    localparam int DATA_W = 32;

    // Codes 5 and 15 are deliberately unassigned; they decode to a zero result.
    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SLL  = 4'd3,
        ALU_SRL  = 4'd4,
        ALU_SUB  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_ADDU = 4'd8,
        ALU_SUBU = 4'd9,
        ALU_XOR  = 4'd10,
        ALU_SLTU = 4'd11,
        ALU_NOR  = 4'd12,
        ALU_SRA  = 4'd13,
        ALU_LUI  = 4'd14
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: selects one of 14 operations and flags a zero result.
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        ctrl_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    logic [4:0] shamt;

    assign shamt = b_i[4:0];

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves result_o unassigned (no latch).
        result_o = '0;
        case (alu_op_e'(ctrl_i))
            ALU_AND:            result_o = a_i & b_i;
            ALU_OR:             result_o = a_i | b_i;
            ALU_ADD, ALU_ADDU:  result_o = a_i + b_i;
            ALU_SUB, ALU_SUBU:  result_o = a_i - b_i;
            ALU_SLL:            result_o = a_i << shamt;
            ALU_SRL:            result_o = a_i >> shamt;
            ALU_SRA:            result_o = $signed(a_i) >>> shamt;
            ALU_SLT:            result_o = {{(DATA_W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU:           result_o = {{(DATA_W-1){1'b0}}, a_i < b_i};
            ALU_XOR:            result_o = a_i ^ b_i;
            ALU_NOR:            result_o = ~(a_i | b_i);
            ALU_LUI:            result_o = {b_i[15:0], 16'h0000};
            default:            result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_reg.sv
// Execute-stage ALU with registered result and zero flag (one cycle latency, sync active-low reset).
module alu_reg
    import alu_pkg::*;
(
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic [DATA_W-1:0] BusA,
    input  logic [DATA_W-1:0] BusB,
    input  logic [3:0]        ALUCtrl,
    output logic [DATA_W-1:0] BusW,
    output logic              Zero
);

    logic [DATA_W-1:0] busw_d, busw_q;
    logic              zero_d, zero_q;

    alu_core u_core (
        .a_i      (BusA),
        .b_i      (BusB),
        .ctrl_i   (ALUCtrl),
        .result_o (busw_d),
        .zero_o   (zero_d)
    );

    // Reset lives inside the clocked block, so it only takes effect on a rising edge.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!Reset_L) begin
            busw_q <= '0;
            zero_q <= 1'b1;
        end else begin
            busw_q <= busw_d;
            zero_q <= zero_d;
        end
    end

    assign BusW = busw_q;
    assign Zero = zero_q;

endmodule

// File: tb/tb_alu_reg.sv
// Scoreboard bench for alu_reg: directed vectors plus randomized traffic against a behavioural model.
module tb_alu_reg;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic [31:0] BusA = '0;
    logic [31:0] BusB = '0;
    logic [3:0]  ALUCtrl = '0;
    logic [31:0] BusW;
    logic        Zero;

    typedef struct {
        logic [31:0] busw;
        logic        zero;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    alu_reg dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .BusA    (BusA),
        .BusB    (BusB),
        .ALUCtrl (ALUCtrl),
        .BusW    (BusW),
        .Zero    (Zero)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model from the operation definitions, using plain integer arithmetic.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input int op);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        int     sh = int'(b % 32);
        longint p  = 1;
        longint r  = 0;
        repeat (sh) p = p * 2;
        case (op)
            0:       r = longint'(a & b);
            1:       r = longint'(a | b);
            2, 8:    r = ua + ub;
            6, 9:    r = ua - ub;
            3:       r = ua * p;
            4:       r = ua / p;
            13:      r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
            7:       r = (sa < sb) ? 1 : 0;
            11:      r = (ua < ub) ? 1 : 0;
            10:      r = longint'(a ^ b);
            12:      r = longint'(~(a | b));
            14:      r = (ub % 65536) * 65536;
            default: r = 0;
        endcase
        return 32'(r);
    endfunction

    task automatic drive(input logic rst_l, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] exp_w, input string name);
        exp_t e;
        @(negedge CLK);
        Reset_L = rst_l;
        BusA    = a;
        BusB    = b;
        ALUCtrl = op;
        e.busw  = rst_l ? exp_w : 32'h0;
        e.zero  = rst_l ? (exp_w == 32'h0) : 1'b1;
        e.name  = name;
        sb_q.push_back(e);
    endtask

    task automatic drive_model(input logic rst_l, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op, input string name);
        drive(rst_l, a, b, op, ref_alu(a, b, int'(op)), name);
    endtask

    // Monitor: the DUT presents a result every cycle; compare one queued expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".BusW"}, BusW, e.busw);
                check({e.name, ".Zero"}, {31'h0, Zero}, {31'h0, e.zero});
            end
        end
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        logic [3:0]  op;
        logic        rst_l;

        drive(1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 4'd2, 32'h0, "reset0");
        drive(1'b0, 32'hFFFF_FFFF, 32'h1, 4'd2, 32'h0, "reset1");
        drive(1'b1, 32'h11, 32'h2, 4'd2, 32'h13, "release_add");

        drive(1'b1, 32'h0, 32'h0, 4'd8, 32'h0, "addu_zero");
        drive(1'b1, 32'h0000_00FF, 32'h1, 4'd8, 32'h0000_0100, "addu_carry");
        drive(1'b1, 32'h0, 32'hFFFF_FFFF, 4'd8, 32'hFFFF_FFFF, "addu_max");
        drive(1'b1, 32'h1, 32'hFFFF_FFFF, 4'd9, 32'h2, "subu_wrap");
        drive(1'b1, 32'h1, 32'hFFFF_FFFF, 4'd6, 32'h2, "sub_wrap");
        drive(1'b1, 32'h1, 32'h1, 4'd9, 32'h0, "subu_zero");

        drive(1'b1, 32'hF0F0_F0F0, 32'h0000_FFFF, 4'd10, 32'hF0F0_0F0F, "xor_a");
        drive(1'b1, 32'h1234_5678, 32'h8765_4321, 4'd10, 32'h9551_1559, "xor_b");
        drive(1'b1, 32'hF0F0_F0F0, 32'h0000_FFFF, 4'd12, 32'h0F0F_0000, "nor_a");
        drive(1'b1, 32'h1234_5678, 32'h8765_4321, 4'd12, 32'h688A_A886, "nor_b");

        drive(1'b1, 32'h0, 32'h0, 4'd11, 32'h0, "sltu_eq");
        drive(1'b1, 32'h0, 32'h1, 4'd11, 32'h1, "sltu_0_1");
        drive(1'b1, 32'h0, 32'hFFFF_FFFF, 4'd11, 32'h1, "sltu_0_max");
        drive(1'b1, 32'hFFFF_FFFF, 32'h0, 4'd11, 32'h0, "sltu_max_0");
        drive(1'b1, 32'h1, 32'h0, 4'd11, 32'h0, "sltu_1_0");
        drive(1'b1, 32'hFFFF_FFFF, 32'h0, 4'd7, 32'h1, "slt_neg");

        drive(1'b1, 32'hFFFF_1234, 32'd6, 4'd4, 32'h03FF_FC48, "srl_6");
        drive(1'b1, 32'hFFFF_1234, 32'd6, 4'd13, 32'hFFFF_FC48, "sra_neg");
        drive(1'b1, 32'h0000_1234, 32'd6, 4'd13, 32'h0000_0048, "sra_pos");
        drive(1'b1, 32'h1, 32'd3, 4'd13, 32'h0, "sra_to_zero");
        drive(1'b1, 32'h1, 32'h21, 4'd3, 32'h2, "sll_masked");

        drive(1'b1, 32'hAAAA_AAAA, 32'h1234_5678, 4'd14, 32'h5678_0000, "lui_a");
        drive(1'b1, 32'h5555_5555, 32'h0000_1234, 4'd14, 32'h1234_0000, "lui_b");
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'h0, "unused15");
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 32'h0, "unused5");

        drive(1'b1, 32'h10, 32'h20, 4'd2, 32'h30, "stream_add0");
        drive(1'b1, 32'h100, 32'h200, 4'd2, 32'h300, "stream_add1");
        drive(1'b0, 32'h1000, 32'h2000, 4'd2, 32'h0, "stream_reset");
        drive(1'b1, 32'h5, 32'h7, 4'd2, 32'hC, "stream_add2");

        for (int i = 0; i < 400; i++) begin
            a     = pick_operand();
            b     = pick_operand();
            op    = 4'($urandom_range(0, 15));
            rst_l = ($urandom_range(0, 24) != 0);
            drive_model(rst_l, a, b, op, $sformatf("rand%0d_op%0d", i, op));
        end

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge CLK);
        #2;
        if (sb_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_reg.md
Name: alu_reg

Overview:
- 32-bit MIPS-style integer ALU for the single-cycle datapath execute stage.
- Computes one of 14 operations on BusA/BusB, selected by a 4-bit ALUCtrl code, and produces the result and a zero flag.
- Outputs are registered: one clock of latency and a synchronous active-low reset.

Parameters:
- None. Data width is fixed at 32 bits and the ALUCtrl encoding is fixed.

Ports:
- CLK      input   1   clock; all state updates on the rising edge
- Reset_L  input   1   synchronous active-low reset
- BusA     input   32  operand A; the value being shifted for SLL/SRL/SRA
- BusB     input   32  operand B; shift amount source (bits [4:0]) for shifts; immediate source for LUI
- ALUCtrl  input   4   operation select
- BusW     output  32  registered result
- Zero     output  1   registered flag: 1 when BusW == 0

Behaviour:
- Reset: on a rising CLK with Reset_L=0, BusW <= 0 and Zero <= 1. Reset overrides any operation in the same cycle.
- Normal operation: on each rising CLK with Reset_L=1, BusW <= f(BusA, BusB, ALUCtrl) and Zero <= (f(...) == 0).
- Latency is exactly 1 cycle. There is no enable and no handshake; a new operation is accepted every cycle.
- ALUCtrl encoding:
  - 0 AND: A & B
  - 1 OR: A | B
  - 2 ADD: A + B, wrap modulo 2^32, no overflow trap or flag
  - 3 SLL: A << B[4:0]
  - 4 SRL: A >> B[4:0], logical, zero fill
  - 6 SUB: A - B, wrap modulo 2^32
  - 7 SLT: 1 if signed(A) < signed(B), else 0
  - 8 ADDU: A + B, wrap modulo 2^32
  - 9 SUBU: A - B, wrap modulo 2^32
  - 10 XOR: A ^ B
  - 11 SLTU: 1 if unsigned(A) < unsigned(B), else 0
  - 12 NOR: ~(A | B)
  - 13 SRA: A >>> B[4:0], arithmetic, sign fill from A[31]
  - 14 LUI: {B[15:0], 16'h0000}; A is ignored
  - 5, 15 (unused): result 0, so Zero = 1
- ADD and ADDU produce bit-identical results; SUB and SUBU produce bit-identical results.
- SLT and SLTU results are zero-extended to 32 bits (only 0 or 1).
- Shifts use only B[4:0]; B[31:5] is ignored. A shift amount of 0 passes A through unchanged.
- Zero is always consistent with the BusW value registered in the same cycle.
- No X propagation requirement beyond standard synthesis semantics; all codes are fully decoded.

Decomposition:
- Shared package alu_pkg holds:
  - a 4-bit enum/localparams for the ALUCtrl codes (ALU_AND … ALU_LUI)
  - the data-width constant 32
- One natural sub-module: alu_core, purely combinational (A, B, ctrl -> result, zero).
- alu_reg wraps alu_core with the output register and reset logic.

Test Plan:
- Reset: hold Reset_L=0 for 2 cycles with any inputs -> BusW=0, Zero=1. Then release with A=0x11, B=0x2, ctrl=2 -> one cycle later BusW=0x13, Zero=0.
- Add/sub, one vector per cycle, each result appearing one cycle after it is applied:
  - ADDU 0+0 -> 0, Zero=1
  - ADDU 0x000000FF+1 -> 0x00000100
  - ADDU 0+0xFFFFFFFF -> 0xFFFFFFFF
  - SUBU 1-0xFFFFFFFF -> 2
  - SUB 1-0xFFFFFFFF -> 2
  - SUBU 1-1 -> 0, Zero=1
- Logic:
  - XOR 0xF0F0F0F0,0x0000FFFF -> 0xF0F00F0F
  - XOR 0x12345678,0x87654321 -> 0x95511559
  - NOR 0xF0F0F0F0,0x0000FFFF -> 0x0F0F0000
  - NOR 0x12345678,0x87654321 -> 0x688AA886
- Compares:
  - SLTU 0,0 -> 0, Zero=1
  - SLTU 0,1 -> 1
  - SLTU 0,0xFFFFFFFF -> 1
  - SLTU 0xFFFFFFFF,0 -> 0
  - SLTU 1,0 -> 0
  - SLT 0xFFFFFFFF,0 -> 1
- Shifts:
  - SRL 0xFFFF1234 by 6 -> 0x03FFFC48
  - SRA 0xFFFF1234 by 6 -> 0xFFFFFC48
  - SRA 0x00001234 by 6 -> 0x00000048
  - SRA 1 by 3 -> 0, Zero=1
  - SLL 1 by B=0x21 -> 2 (only B[4:0] used)
- LUI / unused codes / mid-stream reset:
  - LUI B=0x12345678 -> 0x56780000
  - LUI B=0x00001234 -> 0x12340000
  - ctrl=15 -> BusW=0, Zero=1
  - Reset_L=0 asserted during a stream of ADDs -> next edge gives BusW=0, Zero=1
